// File: rtl/axi_dbg_sram_slave.sv
// rtl/axi_dbg_sram_slave.sv - AXI4 slave backed by an internal single-port RAM for JTAG debug bring-up
// Serves one transaction at a time; FIXED/INCR bursts, WRAP/reserved bursts complete with SLVERR.
module axi_dbg_sram_slave #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int AXI_ID_WIDTH   = 8,
  parameter int MEM_DEPTH      = 256,
  parameter int AXI_DATA_STRB  = AXI_DATA_WIDTH / 8
) (
  input  logic                      axi_aclk,
  input  logic                      axi_aresetn,
  input  logic                      axi_slave_aw_valid,
  output logic                      axi_slave_aw_ready,
  input  logic [AXI_ID_WIDTH-1:0]   axi_slave_aw_id,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_slave_aw_addr,
  input  logic [7:0]                axi_slave_aw_len,
  input  logic [1:0]                axi_slave_aw_burst,
  input  logic                      axi_slave_w_valid,
  output logic                      axi_slave_w_ready,
  input  logic [AXI_DATA_WIDTH-1:0] axi_slave_w_data,
  input  logic [AXI_DATA_STRB-1:0]  axi_slave_w_strb,
  input  logic                      axi_slave_w_last,
  output logic                      axi_slave_b_valid,
  input  logic                      axi_slave_b_ready,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_b_id,
  output logic [1:0]                axi_slave_b_resp,
  input  logic                      axi_slave_ar_valid,
  output logic                      axi_slave_ar_ready,
  input  logic [AXI_ID_WIDTH-1:0]   axi_slave_ar_id,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_slave_ar_addr,
  input  logic [7:0]                axi_slave_ar_len,
  input  logic [1:0]                axi_slave_ar_burst,
  output logic                      axi_slave_r_valid,
  input  logic                      axi_slave_r_ready,
  output logic [AXI_DATA_WIDTH-1:0] axi_slave_r_data,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_r_id,
  output logic [1:0]                axi_slave_r_resp,
  output logic                      axi_slave_r_last
);

  localparam int OFF_W = $clog2(AXI_DATA_STRB);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RADDR, RDATA} state_t;

  state_t                    state_q, state_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [7:0]                len_q, len_d;
  logic [1:0]                burst_q, burst_d;
  logic [8:0]                cnt_q, cnt_d;
  logic [1:0]                bresp_q, bresp_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      live_q;

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                      mem_we;
  logic                      burst_err;
  logic                      last_beat;
  logic [IDX_W-1:0]          idx_next;
  logic                      unused_addr;

  // WRAP and reserved encodings both have bit 1 set
  assign burst_err   = burst_q[1];
  assign last_beat   = (cnt_q == {1'b0, len_q});
  assign idx_next    = (burst_q == BURST_INCR) ? idx_q + IDX_W'(1) : idx_q;
  assign unused_addr = ^{axi_slave_aw_addr, axi_slave_ar_addr};

  assign axi_slave_b_id   = id_q;
  assign axi_slave_b_resp = bresp_q;
  assign axi_slave_r_id   = id_q;
  assign axi_slave_r_data = rdata_q;
  assign axi_slave_r_last = (state_q == RDATA) && last_beat;
  assign axi_slave_r_resp = ((state_q == RDATA) && burst_err) ? RESP_SLVERR : RESP_OKAY;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    idx_d   = idx_q;
    len_d   = len_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    bresp_d = bresp_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    axi_slave_aw_ready = 1'b0;
    axi_slave_ar_ready = 1'b0;
    axi_slave_w_ready  = 1'b0;
    axi_slave_b_valid  = 1'b0;
    axi_slave_r_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        axi_slave_aw_ready = live_q;
        axi_slave_ar_ready = live_q && !axi_slave_aw_valid;
        if (live_q && axi_slave_aw_valid) begin
          id_d    = axi_slave_aw_id;
          idx_d   = axi_slave_aw_addr[OFF_W +: IDX_W];
          len_d   = axi_slave_aw_len;
          burst_d = axi_slave_aw_burst;
          cnt_d   = '0;
          state_d = WDATA;
        end else if (live_q && axi_slave_ar_valid) begin
          id_d    = axi_slave_ar_id;
          idx_d   = axi_slave_ar_addr[OFF_W +: IDX_W];
          len_d   = axi_slave_ar_len;
          burst_d = axi_slave_ar_burst;
          cnt_d   = '0;
          state_d = RADDR;
        end
      end
      WDATA: begin
        axi_slave_w_ready = 1'b1;
        if (axi_slave_w_valid) begin
          // Overrun beats are swallowed; the counter saturates so it cannot alias back to len
          mem_we = !burst_err && (cnt_q <= {1'b0, len_q});
          idx_d  = idx_next;
          cnt_d  = (cnt_q == 9'h1FF) ? cnt_q : cnt_q + 9'd1;
          if (axi_slave_w_last) begin
            bresp_d = (last_beat && !burst_err) ? RESP_OKAY : RESP_SLVERR;
            state_d = WRESP;
          end
        end
      end
      WRESP: begin
        axi_slave_b_valid = 1'b1;
        if (axi_slave_b_ready) state_d = IDLE;
      end
      RADDR: begin
        rdata_d = burst_err ? '0 : mem[idx_q];
        state_d = RDATA;
      end
      RDATA: begin
        axi_slave_r_valid = 1'b1;
        if (axi_slave_r_ready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_next;
            cnt_d   = cnt_q + 9'd1;
            state_d = RADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q <= IDLE;
      id_q    <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      bresp_q <= '0;
      rdata_q <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      bresp_q <= bresp_d;
      rdata_q <= rdata_d;
      live_q  <= 1'b1;
    end
  end

  // RAM has no reset so its contents survive a mid-transaction reset
  always_ff @(posedge axi_aclk) begin
    if (mem_we) begin
      for (int b = 0; b < AXI_DATA_STRB; b++) begin
        if (axi_slave_w_strb[b]) mem[idx_q][b*8 +: 8] <= axi_slave_w_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_dbg_sram_slave.sv
// tb/tb_axi_dbg_sram_slave.sv - directed self-checking bench for axi_dbg_sram_slave
module tb_axi_dbg_sram_slave;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int IW = 8;
  localparam int SW = DW / 8;
  localparam logic [SW-1:0] ALL = {SW{1'b1}};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic          ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [IW-1:0] aw_id, ar_id, b_id, r_id;
  logic [AW-1:0] aw_addr, ar_addr;
  logic [7:0]    aw_len, ar_len;
  logic [1:0]    aw_burst, ar_burst, b_resp, r_resp;
  logic [DW-1:0] w_data, r_data;
  logic [SW-1:0] w_strb;

  axi_dbg_sram_slave dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .axi_slave_aw_valid(aw_valid), .axi_slave_aw_ready(aw_ready), .axi_slave_aw_id(aw_id),
    .axi_slave_aw_addr(aw_addr), .axi_slave_aw_len(aw_len), .axi_slave_aw_burst(aw_burst),
    .axi_slave_w_valid(w_valid), .axi_slave_w_ready(w_ready), .axi_slave_w_data(w_data),
    .axi_slave_w_strb(w_strb), .axi_slave_w_last(w_last),
    .axi_slave_b_valid(b_valid), .axi_slave_b_ready(b_ready), .axi_slave_b_id(b_id),
    .axi_slave_b_resp(b_resp),
    .axi_slave_ar_valid(ar_valid), .axi_slave_ar_ready(ar_ready), .axi_slave_ar_id(ar_id),
    .axi_slave_ar_addr(ar_addr), .axi_slave_ar_len(ar_len), .axi_slave_ar_burst(ar_burst),
    .axi_slave_r_valid(r_valid), .axi_slave_r_ready(r_ready), .axi_slave_r_data(r_data),
    .axi_slave_r_id(r_id), .axi_slave_r_resp(r_resp), .axi_slave_r_last(r_last)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] wdat [16];
  logic [SW-1:0] wstb [16];
  logic [DW-1:0] rdat [16];
  logic [1:0]    rrsp [16];
  logic          rlst [16];
  logic [IW-1:0] rid  [16];
  int            rlat [16];
  int            rbeats;
  int            blat;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [31:0] k);
    return {8{k}};
  endfunction

  task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int nbeats, input int bstall,
                          output logic [1:0] resp, output logic [IW-1:0] bid);
    int t;
    resp = 2'bxx;
    bid  = 'x;
    b_ready  = (bstall == 0);
    aw_valid = 1'b1; aw_id = id; aw_addr = addr; aw_len = len; aw_burst = burst;
    t = 0;
    @(negedge clk);
    while (!aw_ready && t < 50) begin t++; @(negedge clk); end
    if (t >= 50) begin chk("aw_timeout", 0, 1); aw_valid = 1'b0; return; end
    @(posedge clk); #1;
    aw_valid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      w_valid = 1'b1; w_data = wdat[b]; w_strb = wstb[b]; w_last = (b == nbeats - 1);
      t = 0;
      @(negedge clk);
      while (!w_ready && t < 50) begin t++; @(negedge clk); end
      if (t >= 50) begin chk("w_timeout", 0, 1); w_valid = 1'b0; return; end
      @(posedge clk); #1;
    end
    w_valid = 1'b0; w_last = 1'b0;
    t = 0;
    @(negedge clk);
    while (!b_valid && t < 50) begin t++; @(negedge clk); end
    if (t >= 50) begin chk("b_timeout", 0, 1); return; end
    blat = t;
    resp = b_resp;
    bid  = b_id;
    for (int k = 0; k < bstall; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("b_stall%0d valid", k), b_valid, 1);
      chk($sformatf("b_stall%0d resp", k), b_resp, resp);
      chk($sformatf("b_stall%0d id", k), b_id, bid);
    end
    if (bstall > 0) begin @(posedge clk); #1; b_ready = 1'b1; end
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input int stall);
    int  t;
    bit  done;
    rbeats  = 0;
    r_ready = (stall == 0);
    ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len; ar_burst = burst;
    t = 0;
    @(negedge clk);
    while (!ar_ready && t < 50) begin t++; @(negedge clk); end
    if (t >= 50) begin chk("ar_timeout", 0, 1); ar_valid = 1'b0; return; end
    @(posedge clk); #1;
    ar_valid = 1'b0;
    done = 1'b0;
    while (!done && rbeats < 16) begin
      t = 0;
      @(negedge clk);
      while (!r_valid && t < 50) begin t++; @(negedge clk); end
      if (t >= 50) begin
        chk("r_timeout", 0, 1);
        done = 1'b1;
      end else begin
        rlat[rbeats] = t;
        rdat[rbeats] = r_data;
        rrsp[rbeats] = r_resp;
        rlst[rbeats] = r_last;
        rid[rbeats]  = r_id;
        if (stall > 0 && rbeats == 0) begin
          for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("r_stall%0d valid", k), r_valid, 1);
            chk($sformatf("r_stall%0d data", k), r_data, rdat[0]);
            chk($sformatf("r_stall%0d id", k), r_id, rid[0]);
            chk($sformatf("r_stall%0d resp", k), r_resp, rrsp[0]);
            chk($sformatf("r_stall%0d last", k), r_last, rlst[0]);
          end
          @(posedge clk); #1;
          r_ready = 1'b1;
        end
        @(posedge clk); #1;
        if (rlst[rbeats]) done = 1'b1;
        rbeats++;
      end
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [SW-1:0] strb;
    logic [31:0] seed;
    logic [1:0]  eresp;
    logic [31:0] eseed;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [1:0]    resp;
    logic [IW-1:0] bid;
    int            t;

    rst_n = 1'b0;
    aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_burst = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_burst = 0; r_ready = 0;

    tbl[0]  = '{1'b1, 32'h40,   2'b01, ALL,     32'hA1A1A1A1, 2'b00, 32'h0};
    tbl[1]  = '{1'b0, 32'h40,   2'b01, ALL,     32'h0,        2'b00, 32'hA1A1A1A1};
    tbl[2]  = '{1'b1, 32'h2040, 2'b01, ALL,     32'hB2B2B2B2, 2'b00, 32'h0};
    tbl[3]  = '{1'b0, 32'h40,   2'b01, ALL,     32'h0,        2'b00, 32'hB2B2B2B2};
    tbl[4]  = '{1'b1, 32'h5F,   2'b01, {SW{1'b0}}, 32'hC3C3C3C3, 2'b00, 32'h0};
    tbl[5]  = '{1'b0, 32'h47,   2'b01, ALL,     32'h0,        2'b00, 32'hB2B2B2B2};
    tbl[6]  = '{1'b1, 32'h60,   2'b00, ALL,     32'hD4D4D4D4, 2'b00, 32'h0};
    tbl[7]  = '{1'b0, 32'h60,   2'b00, ALL,     32'h0,        2'b00, 32'hD4D4D4D4};
    tbl[8]  = '{1'b1, 32'h60,   2'b11, ALL,     32'hE5E5E5E5, 2'b10, 32'h0};
    tbl[9]  = '{1'b0, 32'h60,   2'b01, ALL,     32'h0,        2'b00, 32'hD4D4D4D4};
    tbl[10] = '{1'b0, 32'h60,   2'b11, ALL,     32'h0,        2'b10, 32'h0};
    tbl[11] = '{1'b1, 32'h80,   2'b10, ALL,     32'hF6F6F6F6, 2'b10, 32'h0};
    tbl[12] = '{1'b0, 32'h80,   2'b10, ALL,     32'h0,        2'b10, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst aw_ready", aw_ready, 0);
    chk("rst ar_ready", ar_ready, 0);
    chk("rst w_ready", w_ready, 0);
    chk("rst b_valid", b_valid, 0);
    chk("rst r_valid", r_valid, 0);
    chk("rst r_data", r_data, 0);
    chk("rst r_id", r_id, 0);
    chk("rst r_resp", r_resp, 0);
    chk("rst r_last", r_last, 0);
    chk("rst b_id", b_id, 0);
    chk("rst b_resp", b_resp, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-rst aw_ready", aw_ready, 1);
    chk("post-rst ar_ready", ar_ready, 1);

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].wr) begin
        wdat[0] = pat(tbl[i].seed);
        wstb[0] = tbl[i].strb;
        do_write(8'(i + 1), tbl[i].addr, 8'd0, tbl[i].burst, 1, 0, resp, bid);
        chk($sformatf("vec%0d b_resp", i), resp, tbl[i].eresp);
        chk($sformatf("vec%0d b_id", i), bid, 8'(i + 1));
        chk($sformatf("vec%0d b_lat", i), blat, 0);
      end else begin
        do_read(8'(i + 1), tbl[i].addr, 8'd0, tbl[i].burst, 0);
        chk($sformatf("vec%0d beats", i), rbeats, 1);
        chk($sformatf("vec%0d r_data", i), rdat[0], pat(tbl[i].eseed));
        chk($sformatf("vec%0d r_resp", i), rrsp[0], tbl[i].eresp);
        chk($sformatf("vec%0d r_last", i), rlst[0], 1);
        chk($sformatf("vec%0d r_id", i), rid[0], 8'(i + 1));
        chk($sformatf("vec%0d r_lat", i), rlat[0], 1);
      end
    end

    // INCR burst crossing the top of the RAM
    for (int k = 0; k < 4; k++) begin wdat[k] = pat(32'h100 + k); wstb[k] = ALL; end
    do_write(8'h21, 32'h1FC0, 8'd3, 2'b01, 4, 0, resp, bid);
    chk("wrap b_resp", resp, 2'b00);
    do_read(8'h22, 32'h1FC0, 8'd3, 2'b01, 0);
    chk("wrap beats", rbeats, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wrap beat%0d data", k), rdat[k], pat(32'h100 + k));
      chk($sformatf("wrap beat%0d last", k), rlst[k], (k == 3));
      chk($sformatf("wrap beat%0d lat", k), rlat[k], 1);
    end
    do_read(8'h23, 32'h0, 8'd0, 2'b01, 0);
    chk("wrap word0", rdat[0], pat(32'h102));
    do_read(8'h24, 32'h1FE0, 8'd0, 2'b01, 0);
    chk("wrap word255", rdat[0], pat(32'h101));

    // Byte strobes on a FIXED burst
    wdat[0] = pat(32'h55555555); wstb[0] = ALL;
    do_write(8'h30, 32'h140, 8'd0, 2'b01, 1, 0, resp, bid);
    wdat[0] = pat(32'h77777777);
    do_write(8'h31, 32'h160, 8'd0, 2'b01, 1, 0, resp, bid);
    wdat[0] = pat(32'hAAAAAAAA); wstb[0] = 32'h0000000F;
    wdat[1] = pat(32'hBBBBBBBB); wstb[1] = 32'hF0000000;
    do_write(8'h32, 32'h140, 8'd1, 2'b00, 2, 0, resp, bid);
    chk("strb b_resp", resp, 2'b00);
    do_read(8'h33, 32'h140, 8'd0, 2'b01, 0);
    chk("strb word10", rdat[0], {{4{8'hBB}}, {24{8'h55}}, {4{8'hAA}}});
    do_read(8'h34, 32'h160, 8'd0, 2'b01, 0);
    chk("strb word11", rdat[0], pat(32'h77777777));

    // AW and AR presented together: write first, read sees new data
    ar_valid = 1'b1; ar_id = 8'h41; ar_addr = 32'h200; ar_len = 0; ar_burst = 2'b01;
    aw_valid = 1'b1; aw_id = 8'h40; aw_addr = 32'h200; aw_len = 0; aw_burst = 2'b01;
    #1;
    chk("sim aw_ready", aw_ready, 1);
    chk("sim ar_ready", ar_ready, 0);
    wdat[0] = pat(32'h5117AAA0); wstb[0] = ALL;
    do_write(8'h40, 32'h200, 8'd0, 2'b01, 1, 0, resp, bid);
    chk("sim b_resp", resp, 2'b00);
    do_read(8'h41, 32'h200, 8'd0, 2'b01, 0);
    chk("sim r_data", rdat[0], pat(32'h5117AAA0));
    chk("sim r_id", rid[0], 8'h41);

    // Early w_last
    for (int k = 0; k < 4; k++) begin wdat[k] = pat(32'h99999999); wstb[k] = ALL; end
    do_write(8'h50, 32'h280, 8'd3, 2'b01, 4, 0, resp, bid);
    wdat[0] = pat(32'hE0); wdat[1] = pat(32'hE1);
    do_write(8'h51, 32'h280, 8'd3, 2'b01, 2, 0, resp, bid);
    chk("early b_resp", resp, 2'b10);
    do_read(8'h52, 32'h280, 8'd3, 2'b01, 0);
    chk("early beats", rbeats, 4);
    chk("early w20", rdat[0], pat(32'hE0));
    chk("early w21", rdat[1], pat(32'hE1));
    chk("early w22", rdat[2], pat(32'h99999999));
    chk("early w23", rdat[3], pat(32'h99999999));

    // Reserved burst on a multi-beat read
    do_read(8'h53, 32'h280, 8'd2, 2'b11, 0);
    chk("rsv beats", rbeats, 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rsv beat%0d resp", k), rrsp[k], 2'b10);
      chk($sformatf("rsv beat%0d data", k), rdat[k], 0);
      chk($sformatf("rsv beat%0d last", k), rlst[k], (k == 2));
    end

    // Extra beat past len is not written
    wdat[0] = pat(32'h31); wstb[0] = ALL;
    do_write(8'h60, 32'h3E0, 8'd0, 2'b01, 1, 0, resp, bid);
    wdat[0] = pat(32'hF0); wdat[1] = pat(32'hF1); wstb[1] = ALL;
    do_write(8'h61, 32'h3C0, 8'd0, 2'b01, 2, 0, resp, bid);
    chk("over b_resp", resp, 2'b10);
    do_read(8'h62, 32'h3C0, 8'd0, 2'b01, 0);
    chk("over w30", rdat[0], pat(32'hF0));
    do_read(8'h63, 32'h3E0, 8'd0, 2'b01, 0);
    chk("over w31", rdat[0], pat(32'h31));

    // Backpressure on B and R
    wdat[0] = pat(32'hC0FFEE00); wstb[0] = ALL;
    do_write(8'h70, 32'h400, 8'd0, 2'b01, 1, 10, resp, bid);
    chk("bp b_resp", resp, 2'b00);
    chk("bp b_id", bid, 8'h70);
    do_read(8'h71, 32'h400, 8'd0, 2'b01, 10);
    chk("bp r_data", rdat[0], pat(32'hC0FFEE00));
    chk("bp r_id", rid[0], 8'h71);

    // Reset in the middle of a read burst
    r_ready = 1'b0;
    ar_valid = 1'b1; ar_id = 8'h5A; ar_addr = 32'h1FC0; ar_len = 8'd3; ar_burst = 2'b01;
    t = 0;
    @(negedge clk);
    while (!ar_ready && t < 50) begin t++; @(negedge clk); end
    if (t >= 50) chk("rst ar_timeout", 0, 1);
    @(posedge clk); #1;
    ar_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!r_valid && t < 50) begin t++; @(negedge clk); end
    if (t >= 50) chk("rst r_timeout", 0, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst r_valid", r_valid, 0);
    chk("midrst b_valid", b_valid, 0);
    chk("midrst aw_ready", aw_ready, 0);
    chk("midrst ar_ready", ar_ready, 0);
    chk("midrst w_ready", w_ready, 0);
    chk("midrst r_data", r_data, 0);
    chk("midrst r_last", r_last, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    r_ready = 1'b1;
    @(posedge clk); #1;
    chk("midrst release aw_ready", aw_ready, 1);
    do_read(8'h5B, 32'h1FC0, 8'd0, 2'b01, 0);
    chk("midrst kept data", rdat[0], pat(32'h100));
    chk("midrst r_resp", rrsp[0], 2'b00);
    chk("midrst r_id", rid[0], 8'h5B);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
